// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared counter mode constants and parameter legality check
//
// Purpose : mode constants for the SATURATE parameter of parametrised counters,
//           plus an elaboration-time legality macro reusable by other
//           parametrised register blocks.
// Ports   : none (package).

`ifndef MOD_COUNTER_PKG_SV
`define MOD_COUNTER_PKG_SV

// Elaboration-time parameter check: instantiates a named generate block that
// raises $error when the condition does not hold. Use at module scope.
`define COUNTER_PARAM_CHECK(label, cond, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end

package mod_counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Number of flag bits carried alongside the count by next_count.
  localparam int CNT_FLAG_BITS = 3;

endpackage

`endif

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised up/down modulus counter with load and flags
//
// Purpose : iteration/step counter with up/down count, programmable modulus,
//           parallel load, wrap or saturate mode, terminal-count decodes and
//           one-cycle event flags.
// Ports   :
//   clk     in   1      clock, rising edge
//   rst     in   1      synchronous active-high reset
//   c_up    in   1      count-up request
//   c_dn    in   1      count-down request
//   ld      in   1      parallel-load strobe (priority over counting)
//   din     in   WIDTH  load value
//   out     out  WIDTH  registered count
//   tc_up   out  1      out == MODULO-1 (combinational)
//   tc_dn   out  1      out == 0 (combinational)
//   wrap    out  1      registered pulse after a boundary wrap
//   sat     out  1      registered pulse after a blocked count (SATURATE=1)
//   ld_err  out  1      registered pulse after an out-of-range load

module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 16,
  parameter int SATURATE  = CNT_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_up,
  input  logic             c_dn,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             wrap,
  output logic             sat,
  output logic             ld_err
);

  `COUNTER_PARAM_CHECK(g_chk_width, (WIDTH >= 2) && (WIDTH <= 16),
                       "mod_counter: WIDTH must be in 2..16")
  `COUNTER_PARAM_CHECK(g_chk_modulo, (MODULO >= 2) && (MODULO <= (1 << WIDTH)),
                       "mod_counter: MODULO must be in 2..2**WIDTH")
  `COUNTER_PARAM_CHECK(g_chk_mode, (SATURATE == CNT_WRAP) || (SATURATE == CNT_SAT),
                       "mod_counter: SATURATE must be CNT_WRAP or CNT_SAT")
  `COUNTER_PARAM_CHECK(g_chk_reset, (RESET_VAL >= 0) && (RESET_VAL < MODULO),
                       "mod_counter: RESET_VAL must be below MODULO")

  // Bounds held in WIDTH+1 bits so MODULO == 2**WIDTH is representable and
  // compares never roll over at 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  // Returns {ld_err, sat, wrap, value} for one non-reset edge.
  function automatic logic [WIDTH+CNT_FLAG_BITS-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic             ld_i,
    input logic [WIDTH-1:0] din_i,
    input logic             up_i,
    input logic             dn_i
  );
    logic [WIDTH:0]   cur_ext;
    logic [WIDTH-1:0] val;
    logic             f_wrap;
    logic             f_sat;
    logic             f_err;
    cur_ext = {1'b0, cur};
    val     = cur;
    f_wrap  = 1'b0;
    f_sat   = 1'b0;
    f_err   = 1'b0;
    if (ld_i) begin
      // din is only looked at in a load cycle, so an undriven din cannot leak X.
      if ({1'b0, din_i} < MOD_EXT) begin
        val = din_i;
      end else begin
        val   = MAX_VAL;
        f_err = 1'b1;
      end
    end else if (up_i && !dn_i) begin
      if (cur_ext < MAX_EXT) begin
        val = WIDTH'(cur_ext + 1'b1);
      end else if (SATURATE == CNT_SAT) begin
        f_sat = 1'b1;
      end else begin
        val    = '0;
        f_wrap = 1'b1;
      end
    end else if (dn_i && !up_i) begin
      if (cur_ext != '0) begin
        val = WIDTH'(cur_ext - 1'b1);
      end else if (SATURATE == CNT_SAT) begin
        f_sat = 1'b1;
      end else begin
        val    = MAX_VAL;
        f_wrap = 1'b1;
      end
    end
    return {f_err, f_sat, f_wrap, val};
  endfunction

  logic [WIDTH+CNT_FLAG_BITS-1:0] nxt;

  always_comb begin
    nxt = next_count(out, ld, din, c_up, c_dn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= RST_VAL;
      wrap   <= 1'b0;
      sat    <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      out    <= nxt[WIDTH-1:0];
      wrap   <= nxt[WIDTH];
      sat    <= nxt[WIDTH+1];
      ld_err <= nxt[WIDTH+2];
    end
  end

  assign tc_up = (out == MAX_VAL);
  assign tc_dn = (out == '0);

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - self-checking bench for mod_counter (wrap, saturate and legacy instances)

module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       c_up = 1'b0;
  logic       c_dn = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] din = 4'd0;

  logic [3:0] dout   [3];
  logic       dtc_up [3];
  logic       dtc_dn [3];
  logic       dwrap  [3];
  logic       dsat   [3];
  logic       derr   [3];

  int checks   = 0;
  int failures = 0;

  // Instance 0: MODULO=10 wrap, 1: MODULO=10 saturate, 2: legacy 16 wrap.
  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .RESET_VAL(0)) dut_wrap (
    .clk(clk), .rst(rst), .c_up(c_up), .c_dn(c_dn), .ld(ld), .din(din),
    .out(dout[0]), .tc_up(dtc_up[0]), .tc_dn(dtc_dn[0]),
    .wrap(dwrap[0]), .sat(dsat[0]), .ld_err(derr[0]));

  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1), .RESET_VAL(0)) dut_sat (
    .clk(clk), .rst(rst), .c_up(c_up), .c_dn(c_dn), .ld(ld), .din(din),
    .out(dout[1]), .tc_up(dtc_up[1]), .tc_dn(dtc_dn[1]),
    .wrap(dwrap[1]), .sat(dsat[1]), .ld_err(derr[1]));

  mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0), .RESET_VAL(0)) dut_legacy (
    .clk(clk), .rst(rst), .c_up(c_up), .c_dn(c_dn), .ld(ld), .din(din),
    .out(dout[2]), .tc_up(dtc_up[2]), .tc_dn(dtc_dn[2]),
    .wrap(dwrap[2]), .sat(dsat[2]), .ld_err(derr[2]));

  always #5 clk = ~clk;

  // Reference model: plain integer counter following the behavioural rules.
  int mmod [3] = '{10, 10, 16};
  int msat [3] = '{0, 1, 0};
  int mv   [3];
  int mw   [3];
  int ms   [3];
  int me   [3];
  int legacy_ref = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      mw[k] = 0;
      ms[k] = 0;
      me[k] = 0;
      if (rst) begin
        mv[k] = 0;
      end else if (ld) begin
        if (int'(din) < mmod[k]) mv[k] = int'(din);
        else begin
          mv[k] = mmod[k] - 1;
          me[k] = 1;
        end
      end else if (c_up && !c_dn) begin
        if (mv[k] < mmod[k] - 1) mv[k] = mv[k] + 1;
        else if (msat[k] == 1) ms[k] = 1;
        else begin
          mv[k] = 0;
          mw[k] = 1;
        end
      end else if (c_dn && !c_up) begin
        if (mv[k] > 0) mv[k] = mv[k] - 1;
        else if (msat[k] == 1) ms[k] = 1;
        else begin
          mv[k] = mmod[k] - 1;
          mw[k] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out[%0d]", k),    int'(dout[k]),   mv[k]);
      check($sformatf("tc_up[%0d]", k),  int'(dtc_up[k]), int'(mv[k] == mmod[k] - 1));
      check($sformatf("tc_dn[%0d]", k),  int'(dtc_dn[k]), int'(mv[k] == 0));
      check($sformatf("wrap[%0d]", k),   int'(dwrap[k]),  mw[k]);
      check($sformatf("sat[%0d]", k),    int'(dsat[k]),   ms[k]);
      check($sformatf("ld_err[%0d]", k), int'(derr[k]),   me[k]);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, sample #1 later.
  task automatic step(input logic r, input logic l, input logic [3:0] d,
                      input logic u, input logic dn);
    rst  = r;
    ld   = l;
    din  = d;
    c_up = u;
    c_dn = dn;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    // Reset then up-count on the MODULO=10 wrap instance.
    step(1, 0, 4'd0, 0, 0);
    step(1, 0, 4'd0, 1, 1);
    check("reset_out", int'(dout[0]), 0);
    check("reset_wrap", int'(dwrap[0]), 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 4'd0, 1, 0);
      check($sformatf("dir_up_out_%0d", i), int'(dout[0]), (i + 1) % 10);
      check($sformatf("dir_up_wrap_%0d", i), int'(dwrap[0]), int'(i == 9));
      check($sformatf("dir_up_tc_%0d", i), int'(dtc_up[0]), int'(i == 8));
    end

    // Down-count wrap from 0.
    step(0, 1, 4'd0, 0, 0);
    check("dn_start_tc_dn", int'(dtc_dn[0]), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'd0, 0, 1);
      check($sformatf("dir_dn_out_%0d", i), int'(dout[0]), 9 - i);
      check($sformatf("dir_dn_wrap_%0d", i), int'(dwrap[0]), int'(i == 0));
      check($sformatf("dir_dn_tc_dn_%0d", i), int'(dtc_dn[0]), 0);
    end

    // Saturate instance: load 8, count up into the bound, then down from 0.
    step(0, 1, 4'd8, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'd0, 1, 0);
      check($sformatf("sat_up_out_%0d", i), int'(dout[1]), 9);
      check($sformatf("sat_up_sat_%0d", i), int'(dsat[1]), int'(i >= 1));
      check($sformatf("sat_up_wrap_%0d", i), int'(dwrap[1]), 0);
    end
    step(0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd0, 0, 1);
    check("sat_dn_out", int'(dout[1]), 0);
    check("sat_dn_sat", int'(dsat[1]), 1);

    // Load priority, out-of-range load, and both-requests hold.
    step(0, 1, 4'd5, 1, 0);
    check("ld_prio_out", int'(dout[0]), 5);
    check("ld_prio_wrap", int'(dwrap[0]), 0);
    step(0, 1, 4'd12, 0, 0);
    check("ld_range_out", int'(dout[0]), 9);
    check("ld_range_err", int'(derr[0]), 1);
    check("ld_legacy_in_range", int'(dout[2]), 12);
    step(0, 0, 4'd0, 1, 1);
    check("hold_out", int'(dout[0]), 9);
    check("hold_err_clear", int'(derr[0]), 0);

    // Reset mid-operation overrides a load.
    step(0, 1, 4'd5, 0, 0);
    step(0, 0, 4'd0, 1, 0);
    check("mid_pre_out", int'(dout[0]), 6);
    step(1, 1, 4'd3, 1, 0);
    check("mid_rst_out", int'(dout[0]), 0);
    step(0, 0, 4'd0, 1, 0);
    check("mid_resume_out", int'(dout[0]), 1);

    // Randomized mixed traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    // Legacy equivalence: only c_up toggles, compare with the fixed 4-bit counter.
    step(1, 0, 4'd0, 0, 0);
    legacy_ref = 0;
    for (int i = 0; i < 60; i++) begin
      logic u;
      int   prev;
      u    = 1'($urandom_range(0, 1));
      prev = legacy_ref;
      step(0, 0, 4'($urandom_range(0, 15)), u, 0);
      legacy_ref = (legacy_ref + int'(u)) % 16;
      check("legacy_out", int'(dout[2]), legacy_ref);
      check("legacy_wrap", int'(dwrap[2]), int'(u && prev == 15));
    end
    // Force the 15 -> 0 transition explicitly.
    step(0, 1, 4'd15, 0, 0);
    step(0, 0, 4'd0, 1, 0);
    check("legacy_15_to_0", int'(dout[2]), 0);
    check("legacy_15_wrap", int'(dwrap[2]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised successor of the 4-bit up-counter used in the ALU16 register set.
- Adds up/down counting, a programmable modulus, parallel load, wrap or saturate mode, and terminal-count and event flags.
- Intended as the iteration/step counter for multi-cycle ALU16 operations (shift-add multiply, restoring divide) and for the sequencer.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..16.
- MODULO, 16: count range is 0..MODULO-1; legal range 2..2**WIDTH; any other value fails at elaboration.
- SATURATE, 0: 0 = wrap at the bounds; 1 = hold at the bounds.
- RESET_VAL, 0: value loaded by reset; must be < MODULO, checked at elaboration.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- c_up  input  1  count-up request.
- c_dn  input  1  count-down request.
- ld  input  1  parallel-load strobe.
- din  input  WIDTH  load value.
- out  output  WIDTH  registered count.
- tc_up  output  1  combinational; high when out == MODULO-1.
- tc_dn  output  1  combinational; high when out == 0.
- wrap  output  1  registered one-cycle pulse; high after a boundary wrap.
- sat  output  1  registered one-cycle pulse; high after a count was blocked at a bound (SATURATE=1 only).
- ld_err  output  1  registered one-cycle pulse; high after a load of an out-of-range value.

Behaviour:
- Reset: when rst is sampled high, the next edge sets out=RESET_VAL and wrap=sat=ld_err=0. rst overrides every other input.
- Priority per edge: rst > ld > count.
- Load: out <= din when din < MODULO. Otherwise out <= MODULO-1 and ld_err pulses. c_up and c_dn are ignored in a load cycle.
- Count decode:
  - c_up=1, c_dn=0: step up.
  - c_dn=1, c_up=0: step down.
  - Both 1 or both 0: hold. No flag pulses in a hold cycle.
- Up step:
  - out < MODULO-1: out+1.
  - out == MODULO-1 and SATURATE=0: out becomes 0, wrap pulses.
  - out == MODULO-1 and SATURATE=1: out holds, sat pulses.
- Down step:
  - out > 0: out-1.
  - out == 0 and SATURATE=0: out becomes MODULO-1, wrap pulses.
  - out == 0 and SATURATE=1: out holds, sat pulses.
- Latency: one cycle from request to out. Flags wrap, sat and ld_err are valid in the same cycle as the out value they describe, and clear on the next edge unless re-triggered.
- Width rules:
  - Arithmetic is done in WIDTH+1 bits internally; no unintended modulo-2**WIDTH rollover when MODULO < 2**WIDTH.
  - For MODULO == 2**WIDTH, MODULO-1 is an all-ones compare constant computed without overflowing WIDTH.
- tc_up and tc_dn are pure decodes of out; no glitch requirement beyond a synchronous consumer.
- Reset mid-count: rst asserted in any cycle discards that cycle's ld and count request. Counting resumes on the first edge after rst is sampled low.
- No state machine beyond the count register and the three flag registers. No X propagation from din when ld=0.

Decomposition:
- Shared include/package counter_defs:
  - Mode constants CNT_WRAP=0 and CNT_SAT=1, used for SATURATE.
  - The elaboration-check macro for parameter legality, reusable by other parametrised register blocks.
- A single module; no sub-module is natural.
- Next-state logic is one function (next_count) returning {flag bits, value}, so the bench reference model can mirror it.
- The existing fixed 4-bit counter stays untouched. mod_counter with WIDTH=4, MODULO=16, SATURATE=0, RESET_VAL=0 and c_dn=ld=0 must match it cycle-for-cycle after reset.

Test Plan (WIDTH=4, MODULO=10 unless stated):
- Reset then up-count: rst=1 for 2 cycles, then c_up=1 for 12 cycles -> out 0..9,0,1,2; wrap high only in the cycle out==0 after 9; tc_up high while out==9.
- Down-count wrap: from 0, c_dn=1 for 3 cycles -> out 9,8,7; wrap pulses with the first 9; tc_dn high only at the initial 0.
- Saturate (SATURATE=1): ld din=8, then c_up for 3 cycles -> out 9,9,9; sat pulses in the 2nd and 3rd cycles; wrap never asserts. Then c_dn from 0 -> out stays 0, sat pulses.
- Load and priority:
  - ld=1, din=5 with c_up=1 -> out=5, no wrap.
  - ld din=12 -> out=9, ld_err pulses one cycle.
  - c_up=c_dn=1 -> out holds, all flags 0.
- Reset mid-operation: counting at out=6, rst=1 with ld=1, din=3 -> out=RESET_VAL (0), flags 0. rst low -> next c_up gives out=1.
- Legacy equivalence: MODULO=16, SATURATE=0, random c_up -> out matches the fixed 4-bit counter model; 15 -> 0 with a wrap pulse.
